// File: rtl/lazy_issue_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lazy_issue_controller_pkg
//  Purpose  : Shared state encoding and default widths for the lazy issue
//             controller and its sequence holding register.
//  Revision : 1.0 - initial release
// ============================================================================
package lazy_issue_controller_pkg;

  // Default geometry: 64-byte jobs, 4-byte lazy window.
  localparam int DEF_JOB_LEN_LOG2    = 6;
  localparam int DEF_LAZY_LEN        = 4;
  localparam int DEF_SEQ_LL_BITS     = 7;
  localparam int DEF_SEQ_ML_BITS     = 8;
  localparam int DEF_SEQ_OFFSET_BITS = 15;
  localparam int DEF_TIMEOUT_CYCLES  = 64;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_SKIP  = 3'd4
  } ctrl_state_t;

  // Width of a counter that must be able to hold max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lazy_seq_out_reg.sv
`default_nettype none
// ============================================================================
//  Module   : lazy_seq_out_reg
//  Purpose  : One-entry valid/ready holding register for committed sequences.
//             Contents are frozen while valid is high and ready is low.
//  Revision : 1.0 - initial release
// ============================================================================
module lazy_seq_out_reg #(
  parameter int LL_BITS     = 7,
  parameter int ML_BITS     = 8,
  parameter int OFFSET_BITS = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [LL_BITS-1:0]     load_ll,
  input  logic [ML_BITS-1:0]     load_ml,
  input  logic [OFFSET_BITS-1:0] load_offset,
  input  logic                   load_eoj,
  input  logic                   load_delim,
  input  logic                   ready,
  output logic                   valid,
  output logic [LL_BITS-1:0]     ll,
  output logic [ML_BITS-1:0]     ml,
  output logic [OFFSET_BITS-1:0] offset,
  output logic                   eoj,
  output logic                   delim
);

  // Capture a new sequence on load, drop valid once the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      ll     <= '0;
      ml     <= '0;
      offset <= '0;
      eoj    <= 1'b0;
      delim  <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      ll     <= load_ll;
      ml     <= load_ml;
      offset <= load_offset;
      eoj    <= load_eoj;
      delim  <= load_delim;
    end else if (valid && ready) begin
      valid  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lazy_issue_controller.sv
`default_nettype none
// ============================================================================
//  Module   : lazy_issue_controller
//  Purpose  : Per-job issue/retire controller. Issues one lazy match request
//             at a time, consumes the returned summary to advance the literal
//             and lazy-window pointers, emits committed sequences and carries
//             the match overlap into the following job.
//  Revision : 1.0 - initial release
// ============================================================================
module lazy_issue_controller
  import lazy_issue_controller_pkg::*;
#(
  parameter int JOB_LEN_LOG2    = DEF_JOB_LEN_LOG2,
  parameter int LAZY_LEN        = DEF_LAZY_LEN,
  parameter int SEQ_LL_BITS     = DEF_SEQ_LL_BITS,
  parameter int SEQ_ML_BITS     = DEF_SEQ_ML_BITS,
  parameter int SEQ_OFFSET_BITS = DEF_SEQ_OFFSET_BITS,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // job intake
  input  logic                       i_job_valid,
  output logic                       o_job_ready,
  input  logic                       i_job_delim,
  // match request
  output logic                       o_req_valid,
  input  logic                       i_req_ready,
  output logic [JOB_LEN_LOG2-1:0]    o_req_match_head_ptr,
  output logic [JOB_LEN_LOG2-1:0]    o_req_seq_head_ptr,
  output logic                       o_req_delim,
  // returned summary
  input  logic                       i_summary_done,
  input  logic [JOB_LEN_LOG2-1:0]    i_summary_seq_head_ptr,
  input  logic [SEQ_LL_BITS-1:0]     i_summary_ll,
  input  logic [SEQ_ML_BITS-1:0]     i_summary_ml,
  input  logic [SEQ_OFFSET_BITS-1:0] i_summary_offset,
  input  logic                       i_summary_delim,
  input  logic                       i_summary_eoj,
  input  logic                       i_move_to_next_job,
  input  logic [SEQ_ML_BITS-1:0]     i_summary_overlap_len,
  input  logic [JOB_LEN_LOG2-1:0]    i_move_forward,
  // committed sequence
  output logic                       o_seq_valid,
  input  logic                       i_seq_ready,
  output logic [SEQ_LL_BITS-1:0]     o_seq_ll,
  output logic [SEQ_ML_BITS-1:0]     o_seq_ml,
  output logic [SEQ_OFFSET_BITS-1:0] o_seq_offset,
  output logic                       o_seq_eoj,
  output logic                       o_seq_delim,
  // errors
  output logic                       o_err_unexpected,
  output logic                       o_err_timeout
);

  localparam int TMR_BITS = cnt_width(TIMEOUT_CYCLES);
  localparam int JOB_LEN  = 1 << JOB_LEN_LOG2;

  localparam logic [JOB_LEN_LOG2-1:0] LAZY_STEP     = JOB_LEN_LOG2'(LAZY_LEN);
  localparam logic [SEQ_ML_BITS-1:0]  JOB_LEN_CARRY = SEQ_ML_BITS'(JOB_LEN);
  localparam logic [TMR_BITS-1:0]     TMR_LIMIT     = TMR_BITS'(TIMEOUT_CYCLES);
  localparam logic [TMR_BITS-1:0]     TMR_ONE       = TMR_BITS'(1);

  ctrl_state_t             state;
  logic [JOB_LEN_LOG2-1:0] seq_head;
  logic [JOB_LEN_LOG2-1:0] match_head;
  logic [SEQ_ML_BITS-1:0]  carry;
  logic                    job_delim;
  logic [TMR_BITS-1:0]     wait_cnt;
  logic                    job_ready;
  logic                    req_valid;
  logic                    err_unexpected;
  logic                    err_timeout;

  logic                    job_fire;
  logic                    req_fire;
  logic                    seq_fire;
  logic                    sum_ok;
  logic                    sum_bad;
  logic                    sum_retire;
  logic                    sum_commit;
  logic                    skip_emit;
  logic [JOB_LEN_LOG2-1:0] next_seq_head;

  logic                       load;
  logic [SEQ_LL_BITS-1:0]     load_ll;
  logic [SEQ_ML_BITS-1:0]     load_ml;
  logic [SEQ_OFFSET_BITS-1:0] load_offset;
  logic                       load_eoj;
  logic                       load_delim;

  // Handshakes and summary classification.
  always_comb begin
    job_fire      = i_job_valid && job_ready;
    req_fire      = req_valid && i_req_ready;
    seq_fire      = o_seq_valid && i_seq_ready;
    // A summary is only meaningful in WAIT and only for the run we asked about.
    sum_ok        = i_summary_done && (state == ST_WAIT) &&
                    (i_summary_seq_head_ptr == seq_head);
    sum_bad       = i_summary_done && !sum_ok;
    // Either end-of-job flag retires the current job.
    sum_retire    = i_summary_eoj || i_move_to_next_job;
    sum_commit    = sum_ok && (sum_retire || (i_summary_ml != '0));
    skip_emit     = (state == ST_SKIP) && job_delim;
    next_seq_head = seq_head + i_move_forward;
  end

  // Select what goes into the sequence register: a summary or a block-closing empty record.
  always_comb begin
    load        = sum_commit || skip_emit;
    load_ll     = i_summary_ll;
    load_ml     = i_summary_ml;
    load_offset = i_summary_offset;
    load_eoj    = sum_retire;
    load_delim  = i_summary_delim;
    if (skip_emit) begin
      load_ll     = '0;
      load_ml     = '0;
      load_offset = '0;
      load_eoj    = 1'b1;
      load_delim  = 1'b1;
    end
  end

  // Main controller: state, pointers, carry, timeout and the registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      seq_head    <= '0;
      match_head  <= '0;
      carry       <= '0;
      job_delim   <= 1'b0;
      wait_cnt    <= '0;
      job_ready   <= 1'b1;
      req_valid   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (job_fire) begin
            seq_head   <= carry[JOB_LEN_LOG2-1:0];
            match_head <= carry[JOB_LEN_LOG2-1:0];
            job_delim  <= i_job_delim;
            job_ready  <= 1'b0;
            // A carry of a whole job or more means this job is fully covered.
            if (carry >= JOB_LEN_CARRY) begin
              state <= ST_SKIP;
            end else begin
              state     <= ST_ISSUE;
              req_valid <= 1'b1;
            end
          end
        end

        ST_ISSUE: begin
          if (req_fire) begin
            req_valid <= 1'b0;
            wait_cnt  <= '0;
            state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (wait_cnt != TMR_LIMIT) begin
            wait_cnt <= wait_cnt + TMR_ONE;
          end
          if (wait_cnt == (TMR_LIMIT - TMR_ONE)) begin
            err_timeout <= 1'b1;
          end
          if (sum_ok) begin
            if (sum_retire) begin
              carry <= job_delim ? '0 : i_summary_overlap_len;
              state <= ST_EMIT;
            end else if (i_summary_ml != '0) begin
              seq_head   <= next_seq_head;
              match_head <= next_seq_head;
              state      <= ST_EMIT;
            end else begin
              // No match committed: slide the lazy window and ask again.
              match_head <= match_head + LAZY_STEP;
              req_valid  <= 1'b1;
              state      <= ST_ISSUE;
            end
          end
        end

        ST_EMIT: begin
          if (seq_fire) begin
            if (o_seq_eoj) begin
              job_ready <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              req_valid <= 1'b1;
              state     <= ST_ISSUE;
            end
          end
        end

        ST_SKIP: begin
          if (job_delim) begin
            carry <= '0;
            state <= ST_EMIT;
          end else begin
            carry     <= carry - JOB_LEN_CARRY;
            job_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          job_ready <= 1'b1;
          req_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // One-cycle error pulse for any summary that arrives out of place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_unexpected <= 1'b0;
    end else begin
      err_unexpected <= sum_bad;
    end
  end

  lazy_seq_out_reg #(
    .LL_BITS     (SEQ_LL_BITS),
    .ML_BITS     (SEQ_ML_BITS),
    .OFFSET_BITS (SEQ_OFFSET_BITS)
  ) u_seq_out (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .load_ll     (load_ll),
    .load_ml     (load_ml),
    .load_offset (load_offset),
    .load_eoj    (load_eoj),
    .load_delim  (load_delim),
    .ready       (i_seq_ready),
    .valid       (o_seq_valid),
    .ll          (o_seq_ll),
    .ml          (o_seq_ml),
    .offset      (o_seq_offset),
    .eoj         (o_seq_eoj),
    .delim       (o_seq_delim)
  );

  assign o_job_ready          = job_ready;
  assign o_req_valid          = req_valid;
  assign o_req_match_head_ptr = match_head;
  assign o_req_seq_head_ptr   = seq_head;
  assign o_req_delim          = job_delim;
  assign o_err_unexpected     = err_unexpected;
  assign o_err_timeout        = err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_lazy_issue_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lazy_issue_controller
//  Purpose  : Scoreboard bench for lazy_issue_controller with a job-level
//             reference model of pointer, carry and sequence behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lazy_issue_controller;

  localparam int W       = 6;
  localparam int LAZY    = 4;
  localparam int LLB     = 7;
  localparam int MLB     = 8;
  localparam int OFB     = 15;
  localparam int TMO     = 64;
  localparam int JOB_LEN = 64;
  localparam int BOUND   = 300;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_job_valid = 1'b0, i_job_delim = 1'b0;
  logic           o_job_ready, o_req_valid, o_req_delim;
  logic           i_req_ready = 1'b0;
  logic [W-1:0]   o_req_match_head_ptr, o_req_seq_head_ptr;
  logic           i_summary_done = 1'b0;
  logic [W-1:0]   i_summary_seq_head_ptr = '0;
  logic [LLB-1:0] i_summary_ll = '0;
  logic [MLB-1:0] i_summary_ml = '0;
  logic [OFB-1:0] i_summary_offset = '0;
  logic           i_summary_delim = 1'b0, i_summary_eoj = 1'b0, i_move_to_next_job = 1'b0;
  logic [MLB-1:0] i_summary_overlap_len = '0;
  logic [W-1:0]   i_move_forward = '0;
  logic           o_seq_valid;
  logic           i_seq_ready;
  logic [LLB-1:0] o_seq_ll;
  logic [MLB-1:0] o_seq_ml;
  logic [OFB-1:0] o_seq_offset;
  logic           o_seq_eoj, o_seq_delim, o_err_unexpected, o_err_timeout;

  always #5 clk = ~clk;

  lazy_issue_controller #(
    .JOB_LEN_LOG2(W), .LAZY_LEN(LAZY), .SEQ_LL_BITS(LLB), .SEQ_ML_BITS(MLB),
    .SEQ_OFFSET_BITS(OFB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_job_valid(i_job_valid), .o_job_ready(o_job_ready), .i_job_delim(i_job_delim),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready),
    .o_req_match_head_ptr(o_req_match_head_ptr), .o_req_seq_head_ptr(o_req_seq_head_ptr),
    .o_req_delim(o_req_delim),
    .i_summary_done(i_summary_done), .i_summary_seq_head_ptr(i_summary_seq_head_ptr),
    .i_summary_ll(i_summary_ll), .i_summary_ml(i_summary_ml), .i_summary_offset(i_summary_offset),
    .i_summary_delim(i_summary_delim), .i_summary_eoj(i_summary_eoj),
    .i_move_to_next_job(i_move_to_next_job), .i_summary_overlap_len(i_summary_overlap_len),
    .i_move_forward(i_move_forward),
    .o_seq_valid(o_seq_valid), .i_seq_ready(i_seq_ready),
    .o_seq_ll(o_seq_ll), .o_seq_ml(o_seq_ml), .o_seq_offset(o_seq_offset),
    .o_seq_eoj(o_seq_eoj), .o_seq_delim(o_seq_delim),
    .o_err_unexpected(o_err_unexpected), .o_err_timeout(o_err_timeout)
  );

  typedef struct { int mh; int sh; bit delim; } req_t;
  typedef struct { int ll; int ml; int off; bit eoj; bit delim; } seq_t;

  req_t exp_req[$];
  seq_t exp_seq[$];
  req_t rq;
  seq_t sq;

  int vectors = 0;
  int miscompares = 0;
  bit err_allowed = 1'b0;
  bit stall = 1'b0;

  // Reference model state (job-level view).
  int m_carry = 0;
  int m_seq = 0;
  int m_match = 0;
  bit m_delim = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endfunction

  function automatic void bound_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got no event within %0d cycles, required one", name, BOUND);
  endfunction

  function automatic void push_req();
    req_t r;
    r.mh = m_match; r.sh = m_seq; r.delim = m_delim;
    exp_req.push_back(r);
  endfunction

  function automatic void push_seq(input int ll, input int ml, input int off, input bit eoj, input bit delim);
    seq_t s;
    s.ll = ll; s.ml = ml; s.off = off; s.eoj = eoj; s.delim = delim;
    exp_seq.push_back(s);
  endfunction

  // Consumer ready: mostly high, forced low while stall is set.
  initial begin
    i_seq_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      i_seq_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: scoreboard pops on handshakes plus hold/exclusion checks.
  logic           prv_rv, prv_rr, prv_rd, prv_sv, prv_sr, prv_eoj, prv_sdl;
  logic [W-1:0]   prv_mh, prv_sh;
  logic [LLB-1:0] prv_ll;
  logic [MLB-1:0] prv_ml;
  logic [OFB-1:0] prv_off;

  always @(negedge clk) begin
    if (!rst_n) begin
      prv_rv = 1'b0;
      prv_sv = 1'b0;
    end else begin
      if (prv_rv && !prv_rr) begin
        check("req_hold_valid", o_req_valid, 1);
        check("req_hold_mh", o_req_match_head_ptr, prv_mh);
        check("req_hold_sh", o_req_seq_head_ptr, prv_sh);
        check("req_hold_delim", o_req_delim, prv_rd);
      end
      if (prv_sv && !prv_sr) begin
        check("seq_hold_valid", o_seq_valid, 1);
        check("seq_hold_ll", o_seq_ll, prv_ll);
        check("seq_hold_ml", o_seq_ml, prv_ml);
        check("seq_hold_off", o_seq_offset, prv_off);
        check("seq_hold_eoj", o_seq_eoj, prv_eoj);
        check("seq_hold_delim", o_seq_delim, prv_sdl);
      end
      if (o_req_valid && i_req_ready) begin
        if (exp_req.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL req_unexpected: got request mh=%0d sh=%0d, required none",
                   o_req_match_head_ptr, o_req_seq_head_ptr);
        end else begin
          rq = exp_req.pop_front();
          check("req_match_head", o_req_match_head_ptr, rq.mh);
          check("req_seq_head", o_req_seq_head_ptr, rq.sh);
          check("req_delim", o_req_delim, rq.delim);
        end
      end
      if (o_seq_valid && i_seq_ready) begin
        if (exp_seq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL seq_unexpected: got seq ll=%0d ml=%0d, required none", o_seq_ll, o_seq_ml);
        end else begin
          sq = exp_seq.pop_front();
          check("seq_ll", o_seq_ll, sq.ll);
          check("seq_ml", o_seq_ml, sq.ml);
          check("seq_offset", o_seq_offset, sq.off);
          check("seq_eoj", o_seq_eoj, sq.eoj);
          check("seq_delim", o_seq_delim, sq.delim);
        end
      end
      if (o_seq_valid) check("no_req_while_seq_pending", o_req_valid, 0);
      if (!err_allowed) check("err_unexpected_quiet", o_err_unexpected, 0);
      prv_rv = o_req_valid; prv_rr = i_req_ready; prv_mh = o_req_match_head_ptr;
      prv_sh = o_req_seq_head_ptr; prv_rd = o_req_delim;
      prv_sv = o_seq_valid; prv_sr = i_seq_ready; prv_ll = o_seq_ll; prv_ml = o_seq_ml;
      prv_off = o_seq_offset; prv_eoj = o_seq_eoj; prv_sdl = o_seq_delim;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input bit delim);
    int n;
    n = 0;
    tick();
    i_job_valid = 1'b1;
    i_job_delim = delim;
    @(negedge clk);
    while (!o_job_ready && n < BOUND) begin @(negedge clk); n++; end
    if (!o_job_ready) begin
      bound_fail("job_accept");
      i_job_valid = 1'b0;
      return;
    end
    m_delim = delim;
    if (m_carry >= JOB_LEN) begin
      m_carry = m_carry - JOB_LEN;
      if (delim) begin
        push_seq(0, 0, 0, 1'b1, 1'b1);
        m_carry = 0;
      end
    end else begin
      m_seq = m_carry;
      m_match = m_carry;
      push_req();
    end
    tick();
    i_job_valid = 1'b0;
  endtask

  task automatic take_req();
    int n;
    n = 0;
    @(negedge clk);
    while (!o_req_valid && n < BOUND) begin @(negedge clk); n++; end
    if (!o_req_valid) begin bound_fail("req_wait"); return; end
    repeat ($urandom_range(0, 2)) @(posedge clk);
    tick();
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
  endtask

  task automatic send_sum(input int ll, input int ml, input int off, input bit eoj,
                          input int ovl, input int mf, input bit ptr_bad);
    repeat ($urandom_range(1, 3)) tick();
    i_summary_done         = 1'b1;
    i_summary_seq_head_ptr = ptr_bad ? W'(m_seq + 1) : W'(m_seq);
    i_summary_ll           = LLB'(ll);
    i_summary_ml           = MLB'(ml);
    i_summary_offset       = OFB'(off);
    i_summary_eoj          = eoj;
    i_move_to_next_job     = eoj;
    i_summary_delim        = eoj ? m_delim : 1'b0;
    i_summary_overlap_len  = MLB'(ovl);
    i_move_forward         = W'(mf);
    if (!ptr_bad) begin
      if (eoj) begin
        push_seq(ll, ml, off, 1'b1, m_delim);
        m_carry = m_delim ? 0 : ovl;
      end else if (ml != 0) begin
        push_seq(ll, ml, off, 1'b0, 1'b0);
        m_seq = (m_seq + mf) % JOB_LEN;
        m_match = m_seq;
        push_req();
      end else begin
        m_match = (m_match + LAZY) % JOB_LEN;
        push_req();
      end
    end
    tick();
    i_summary_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!o_job_ready && n < BOUND) begin @(negedge clk); n++; end
    if (!o_job_ready) bound_fail("idle_wait");
  endtask

  task automatic finish_job(input int ovl);
    take_req();
    send_sum($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(1, 3000), 1'b1, ovl, 0, 1'b0);
    wait_idle();
  endtask

  task automatic pulse_stray_summary();
    tick();
    i_summary_done = 1'b1;
    tick();
    i_summary_done = 1'b0;
  endtask

  task automatic random_job();
    bit delim;
    bit skip;
    int steps;
    int ovl;
    delim = ($urandom_range(0, 3) == 0);
    skip = (m_carry >= JOB_LEN);
    start_job(delim);
    if (skip) begin
      wait_idle();
      return;
    end
    steps = $urandom_range(0, 5);
    for (int s = 0; s < steps; s++) begin
      take_req();
      if ($urandom_range(0, 9) < 5)
        send_sum($urandom_range(0, 20), $urandom_range(3, 30), $urandom_range(1, 30000),
                 1'b0, 0, $urandom_range(1, 20), 1'b0);
      else
        send_sum($urandom_range(0, 20), 0, 0, 1'b0, 0, $urandom_range(0, 20), 1'b0);
    end
    ovl = ($urandom_range(0, 3) == 0) ? $urandom_range(64, 140) : $urandom_range(0, 12);
    finish_job(ovl);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_job_ready", o_job_ready, 1);
    check("rst_req_valid", o_req_valid, 0);
    check("rst_seq_valid", o_seq_valid, 0);
    check("rst_err_unexpected", o_err_unexpected, 0);
    check("rst_err_timeout", o_err_timeout, 0);
    check("rst_req_ptrs", {o_req_match_head_ptr, o_req_seq_head_ptr}, 0);
    tick();
    rst_n = 1'b1;

    // Match, then lazy miss at match_head=20, then retire with overlap 5.
    start_job(1'b0);
    take_req();
    send_sum(3, 8, 100, 1'b0, 0, 11, 1'b0);
    take_req();
    send_sum(5, 6, 200, 1'b0, 0, 9, 1'b0);
    take_req();
    send_sum(0, 0, 0, 1'b0, 0, 7, 1'b0);
    take_req();
    send_sum(2, 4, 30, 1'b1, 5, 0, 1'b0);
    wait_idle();

    // Overlap of 5 carries in; then overlap 70 forces a delim SKIP.
    start_job(1'b0);
    finish_job(70);
    start_job(1'b1);
    wait_idle();
    start_job(1'b0);
    finish_job(70);
    start_job(1'b0);
    wait_idle();

    // Carry of 6 left after a non-delim skip; stall the sequence port.
    start_job(1'b1);
    take_req();
    stall = 1'b1;
    send_sum(4, 5, 11, 1'b0, 0, 3, 1'b0);
    repeat (10) begin
      @(negedge clk);
      check("stall_seq_valid", o_seq_valid, 1);
      check("stall_no_req", o_req_valid, 0);
    end
    stall = 1'b0;
    take_req();

    // Echoed pointer mismatch is dropped with an error pulse.
    err_allowed = 1'b1;
    send_sum(1, 9, 12, 1'b0, 0, 2, 1'b1);
    @(negedge clk);
    check("mismatch_err_pulse", o_err_unexpected, 1);
    @(negedge clk);
    check("mismatch_err_clear", o_err_unexpected, 0);
    err_allowed = 1'b0;
    send_sum(2, 3, 44, 1'b1, 0, 0, 1'b0);
    wait_idle();

    // Summary strobe while idle.
    err_allowed = 1'b1;
    pulse_stray_summary();
    @(negedge clk);
    check("idle_err_pulse", o_err_unexpected, 1);
    check("idle_still_ready", o_job_ready, 1);
    @(negedge clk);
    check("idle_err_clear", o_err_unexpected, 0);
    err_allowed = 1'b0;

    // Randomized jobs.
    repeat (40) random_job();
    while (m_carry >= JOB_LEN) begin
      start_job(1'b0);
      wait_idle();
    end

    // Timeout: no summary for 70 cycles after the request is taken.
    start_job(1'b0);
    take_req();
    repeat (40) @(negedge clk);
    check("timeout_not_yet", o_err_timeout, 0);
    repeat (30) @(negedge clk);
    check("timeout_set", o_err_timeout, 1);
    send_sum(1, 2, 3, 1'b1, 9, 0, 1'b0);
    wait_idle();
    check("timeout_sticky", o_err_timeout, 1);

    // Reset in the middle of a job clears everything, including carry.
    start_job(1'b0);
    take_req();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_job_ready", o_job_ready, 1);
    check("midrst_req_valid", o_req_valid, 0);
    check("midrst_timeout", o_err_timeout, 0);
    check("midrst_seq_valid", o_seq_valid, 0);
    exp_req.delete();
    exp_seq.delete();
    m_carry = 0;
    tick();
    tick();
    rst_n = 1'b1;
    err_allowed = 1'b1;
    pulse_stray_summary();
    @(negedge clk);
    check("late_sum_err_pulse", o_err_unexpected, 1);
    @(negedge clk);
    check("late_sum_err_clear", o_err_unexpected, 0);
    err_allowed = 1'b0;
    start_job(1'b1);
    finish_job(0);

    repeat (5) @(negedge clk);
    check("req_queue_drained", exp_req.size(), 0);
    check("seq_queue_drained", exp_seq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
